// File: rtl/led_pwm_fader.sv
// Multi-channel LED PWM driver with per-channel fade-out trails behind a chaser pattern.
// Each channel loads a brightness on its pattern bit and decays one level every DECAY_DIV periods.
module led_pwm_fader #(
    parameter int unsigned DATA_LEN  = 16,
    parameter int unsigned PWM_BITS  = 4,
    parameter int unsigned DECAY_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_LEN-1:0] pattern_in,
    input  logic [PWM_BITS-1:0] max_level,
    output logic [DATA_LEN-1:0] led_out,
    output logic                period_strobe
);

    localparam int unsigned DecayW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    // Counter runs 0..PERIOD-1 where PERIOD = 2^PWM_BITS - 1, so the last count is 2^PWM_BITS - 2.
    localparam logic [PWM_BITS-1:0] CntLast   = PWM_BITS'((2 ** PWM_BITS) - 2);
    localparam logic [DecayW-1:0]   DecayLast = DecayW'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
    logic [DecayW-1:0]                  decay_cnt_q, decay_cnt_d;
    logic [DATA_LEN-1:0][PWM_BITS-1:0]  level_q, level_d;
    logic [DATA_LEN-1:0][PWM_BITS-1:0]  duty_q, duty_d;
    logic [DATA_LEN-1:0]                led_d;
    logic                               strobe_d;
    logic                               wrap;
    logic                               decay_step;

    always_comb begin
        wrap        = en && (pwm_cnt_q == CntLast);
        decay_step  = wrap && (decay_cnt_q == DecayLast);
        pwm_cnt_d   = pwm_cnt_q;
        decay_cnt_d = decay_cnt_q;
        level_d     = level_q;
        duty_d      = duty_q;
        led_d       = '0;
        strobe_d    = wrap;

        if (en) begin
            pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;
            if (wrap) begin
                decay_cnt_d = decay_step ? '0 : decay_cnt_q + 1'b1;
            end
            for (int i = 0; i < int'(DATA_LEN); i++) begin
                // A fresh load wins over a decay landing on the same edge.
                if (pattern_in[i]) begin
                    level_d[i] = max_level;
                end else if (decay_step && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - 1'b1;
                end
                // Duty only changes at the period boundary so a period never glitches.
                if (wrap) begin
                    duty_d[i] = level_q[i];
                end
                led_d[i] = (pwm_cnt_q < duty_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q     <= '0;
            decay_cnt_q   <= '0;
            level_q       <= '0;
            duty_q        <= '0;
            led_out       <= '0;
            period_strobe <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
            level_q       <= level_d;
            duty_q        <= duty_d;
            led_out       <= led_d;
            period_strobe <= strobe_d;
        end
    end

endmodule

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter DATA_LEN, default 16: number of LED channels.
REQ-002 SHALL have parameter PWM_BITS, default 4: brightness resolution. Legal range 2..8.
REQ-003 SHALL have parameter DECAY_DIV, default 8: PWM periods per one-level fade step. Must be at least 1.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: run enable.
REQ-007 SHALL have port pattern_in, input, DATA_LEN bits: LED on/off pattern from the upstream chaser. Bit i high lights channel i.
REQ-008 SHALL have port max_level, input, PWM_BITS bits: brightness loaded when a pattern bit is high.
REQ-009 SHALL have port led_out, output, DATA_LEN bits: registered PWM drive to the physical LEDs.
REQ-010 SHALL have port period_strobe, output, 1 bit: registered one-cycle pulse at the end of each PWM period.

Function
REQ-011 SHALL define PERIOD = 2^PWM_BITS - 1 cycles. Brightness levels run 0..PERIOD: level 0 is always off, level PERIOD is always on.
REQ-012 SHALL keep pwm_cnt counting 0..PERIOD-1 and wrapping to 0 while en=1. The edge where pwm_cnt goes from PERIOD-1 to 0 is the "wrap edge".
REQ-013 SHALL keep decay_cnt counting 0..DECAY_DIV-1, advancing only on wrap edges. A "decay step" is a wrap edge with decay_cnt=DECAY_DIV-1, and decay_cnt returns to 0 on that edge.
REQ-014 SHALL keep a PWM_BITS-wide level[i] per channel. The per-edge update, with en=1, in priority order:
- If pattern_in[i]=1, level[i] loads max_level.
- Otherwise, on a decay step with level[i]>0, level[i] decrements by 1.
- Otherwise level[i] holds.
REQ-015 SHALL saturate level at 0. Decrementing below 0 never occurs, and level never wraps.
REQ-016 SHALL give the pattern load priority over a decay step on the same edge.
REQ-017 SHALL NOT clamp existing level values when max_level changes. Only new loads use the new max_level.
REQ-018 SHALL keep a shadow duty[i] per channel, updated only on wrap edges: duty[i] <= level[i], using the value before that edge's update. This makes the PWM glitch-free within a period.
REQ-019 SHALL compute each edge, with en=1: led_out[i] <= (pwm_cnt < duty[i]), using pre-edge register values. This is one cycle of output latency.
REQ-020 SHALL assert period_strobe for exactly one cycle, registered, on the edge after pwm_cnt=PERIOD-1 is sampled with en=1.
REQ-021 SHALL behave as follows with en=0:
- pwm_cnt, decay_cnt, level and duty all hold.
- pattern_in is ignored.
- led_out is registered to all-zero on the next edge.
- period_strobe is 0.
REQ-022 SHALL resume counting from the held pwm_cnt value when en returns to 1, with no extra wrap edge.
REQ-023 SHALL give each channel independent behaviour, with no cross-channel coupling.

Reset
REQ-024 SHALL clear immediately while rst=1: pwm_cnt, decay_cnt, all level[i], all duty[i], led_out and period_strobe all go to 0.
REQ-025 SHALL treat reset asserted mid-period or mid-fade as a full clear. After release, operation restarts from pwm_cnt=0 with all channels dark.
REQ-026 SHALL first update state on the first rising clk edge after rst deasserts.

Verification (defaults DATA_LEN=16, PWM_BITS=4, DECAY_DIV=8, PERIOD=15; edges counted from 1 after reset release)
REQ-027 SHALL cover basic turn-on and strobe timing.
- Stimulus: en=1, max_level=15, pattern_in=16'h0001 held.
- Response: led_out[0]=0 through edge 15 and 1 from edge 16 onward. Other bits stay 0. period_strobe pulses after edges 15, 30, 45, and so on.
REQ-028 SHALL cover partial duty.
- Stimulus: max_level=5, pattern_in=16'h8000 held.
- Response: after the second wrap, led_out[15] is high for exactly 5 of every 15 cycles, contiguous.
REQ-029 SHALL cover fade-out.
- Stimulus: channel 3 held at level 15, then pattern_in=0 from a wrap edge.
- Response: high-time per period steps 15 -> 14 -> ... -> 0, one step every 8 periods, with no change inside a period. After that led_out[3] stays 0.
REQ-030 SHALL cover simultaneous load and decay.
- Stimulus: pattern_in[2]=1 asserted on a decay-step edge with level[2]=7 and max_level=9.
- Response: level[2]=9, not 6.
REQ-031 SHALL cover enable pause.
- Stimulus: en dropped for 20 cycles mid-period at pwm_cnt=6.
- Response: led_out=0 from the next edge, period_strobe=0, and pwm_cnt still 6 when en returns. PWM then resumes with the remaining 9 cycles of that period.
REQ-032 SHALL cover reset mid-fade.
- Stimulus: rst pulsed asynchronously between edges during a fade.
- Response: led_out=0 immediately. After release all channels stay dark with pattern_in=0.
